// File: rtl/taylor_trig_engine.sv
// Sequential fp32 sin/cos co-unit: truncated Taylor series evaluated in Horner form,
// time-multiplexing one pipelined fp32 ALU (MUL/ADD) for every step.

module taylor_trig_engine #(
    parameter int MAX_TERMS = 6,
    parameter int ALU_LAT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [3:0]  n_terms,
    input  logic [31:0] x,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    localparam logic [4:0] OP_MUL = 5'b00111;
    localparam logic [4:0] OP_ADD = 5'b00101;
    localparam int         CW     = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [2:0] {S_IDLE, S_SQR, S_MUL, S_ADD, S_FIX, S_DONE} state_t;

    // Signed series coefficients: cos c[k] = (-1)^k/(2k)!, sin c[k] = (-1)^k/(2k+1)!.
    function automatic logic [31:0] coef(input logic sin_sel, input logic [2:0] k);
        logic [31:0] c;
        case ({sin_sel, k})
            4'b0_000: c = 32'h3F80_0000;
            4'b0_001: c = 32'hBF00_0000;
            4'b0_010: c = 32'h3D2A_AAAB;
            4'b0_011: c = 32'hBAB6_0B61;
            4'b0_100: c = 32'h37D0_0D01;
            4'b0_101: c = 32'hB493_F27E;
            4'b0_110: c = 32'h310F_76C7;
            4'b0_111: c = 32'hAD49_CBA5;
            4'b1_000: c = 32'h3F80_0000;
            4'b1_001: c = 32'hBE2A_AAAB;
            4'b1_010: c = 32'h3C08_8889;
            4'b1_011: c = 32'hB950_0D01;
            4'b1_100: c = 32'h3638_EF1D;
            4'b1_101: c = 32'hB2D7_322B;
            4'b1_110: c = 32'h2F30_9231;
            4'b1_111: c = 32'hAB57_3F9F;
            default:  c = 32'h0000_0000;
        endcase
        return c;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      k_q, k_d;
    logic            mode_q, mode_d, busy_q, busy_d, done_q, done_d;
    logic [31:0]     x_q, x_d, x2_q, x2_d, acc_q, acc_d, result_q, result_d;
    logic [3:0]      n_clamp_s;
    logic            op_last_s;
    logic [31:0]     alu_a_s, alu_b_s, alu_out_s;
    logic [4:0]      alu_op_s;

    ALU #(.LAT(ALU_LAT)) u_alu (
        .a      (alu_a_s),
        .b      (alu_b_s),
        .opcode (alu_op_s),
        .clk    (clk),
        .out    (alu_out_s)
    );

    // Clamp the requested series length into 1..MAX_TERMS.
    always_comb begin
        if (n_terms == 4'd0) begin
            n_clamp_s = 4'd1;
        end else if (n_terms > 4'(MAX_TERMS)) begin
            n_clamp_s = 4'(MAX_TERMS);
        end else begin
            n_clamp_s = n_terms;
        end
    end

    assign op_last_s = (cnt_q == CW'(ALU_LAT));

    // Sequencer: k_q indexes the coefficient to fold in next; the ALU result is taken on the last op cycle.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        x_d      = x_q;
        x2_d     = x2_q;
        acc_d    = acc_q;
        result_d = result_q;
        alu_a_s  = acc_q;
        alu_b_s  = x_q;
        alu_op_s = OP_MUL;
        cnt_d    = (op_last_s || state_q == S_IDLE || state_q == S_DONE) ? {CW{1'b0}} : cnt_q + CW'(1);
        case (state_q)
            S_IDLE: begin
                if (start && !done_q) begin
                    x_d     = x;
                    mode_d  = mode;
                    k_d     = 3'(n_clamp_s - 4'd1);
                    busy_d  = 1'b1;
                    state_d = S_SQR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SQR: begin
                alu_a_s = x_q;
                if (op_last_s) begin
                    x2_d  = alu_out_s;
                    acc_d = coef(mode_q, k_q);
                    if (k_q == 3'd0) begin
                        state_d = mode_q ? S_FIX : S_DONE;
                    end else begin
                        k_d     = k_q - 3'd1;
                        state_d = S_MUL;
                    end
                end else begin
                    state_d = S_SQR;
                end
            end
            S_MUL: begin
                alu_b_s = x2_q;
                if (op_last_s) begin
                    acc_d   = alu_out_s;
                    state_d = S_ADD;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_ADD: begin
                alu_b_s  = coef(mode_q, k_q);
                alu_op_s = OP_ADD;
                if (op_last_s) begin
                    acc_d = alu_out_s;
                    if (k_q == 3'd0) begin
                        state_d = mode_q ? S_FIX : S_DONE;
                    end else begin
                        k_d     = k_q - 3'd1;
                        state_d = S_MUL;
                    end
                end else begin
                    state_d = S_ADD;
                end
            end
            S_FIX: begin
                if (op_last_s) begin
                    acc_d   = alu_out_s;
                    state_d = S_DONE;
                end else begin
                    state_d = S_FIX;
                end
            end
            S_DONE: begin
                result_d = acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            k_q      <= 3'd0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            x_q      <= 32'h0000_0000;
            x2_q     <= 32'h0000_0000;
            acc_q    <= 32'h0000_0000;
            result_q <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            x_q      <= x_d;
            x2_q     <= x2_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
endmodule

module ALU #(
    parameter int LAT = 1
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  opcode,
    input  logic        clk,
    output logic [31:0] out
);
    localparam logic [4:0] OP_MUL = 5'b00111;
    localparam logic [4:0] OP_ADD = 5'b00101;

    // Normal-operand fp32 multiply, round-to-nearest-even; zero/denormal operands flush to zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] p_a, input logic [31:0] p_b);
        logic        s, rnd, stk;
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        logic [31:0] r;
        s = p_a[31] ^ p_b[31];
        p = 48'({1'b1, p_a[22:0]}) * 48'({1'b1, p_b[22:0]});
        e = {2'b00, p_a[30:23]} + {2'b00, p_b[30:23]} + {9'd0, p[47]};
        if (p[47]) begin
            m = p[46:24]; rnd = p[23]; stk = |p[22:0];
        end else begin
            m = p[45:23]; rnd = p[22]; stk = |p[21:0];
        end
        if (p_a[30:23] == 8'd0 || p_b[30:23] == 8'd0 || e <= 10'd127) begin
            r = {s, 31'd0};
        end else if (e >= 10'd382) begin
            r = {s, 8'hFF, 23'd0};
        end else begin
            r = {s, 8'(e - 10'd127), m} + {31'd0, rnd & (stk | m[0])};
        end
        return r;
    endfunction

    // Normal-operand fp32 add: align the smaller magnitude, add/subtract, renormalise, round.
    function automatic logic [31:0] fp_add(input logic [31:0] p_a, input logic [31:0] p_b);
        logic [31:0] big, sml, r;
        logic [7:0]  d;
        logic [26:0] ms;
        logic [27:0] sum, nrm;
        logic [4:0]  sh;
        logic [9:0]  e;
        if (p_a[30:0] >= p_b[30:0]) begin
            big = p_a; sml = p_b;
        end else begin
            big = p_b; sml = p_a;
        end
        d  = big[30:23] - sml[30:23];
        ms = (sml[30:23] == 8'd0 || d > 8'd26) ? 27'd0 : ({1'b1, sml[22:0], 3'b000} >> d);
        if (big[31] == sml[31]) begin
            sum = {2'b01, big[22:0], 3'b000} + {1'b0, ms};
        end else begin
            sum = {2'b01, big[22:0], 3'b000} - {1'b0, ms};
        end
        sh = 5'd0;
        for (int i = 0; i < 27; i++) begin
            sh = sum[i] ? 5'(26 - i) : sh;
        end
        if (sum[27]) begin
            nrm = sum >> 1;
            e   = {2'b00, big[30:23]} + 10'd1;
        end else begin
            nrm = sum << sh;
            e   = {2'b00, big[30:23]} - {5'd0, sh};
        end
        if (big[30:23] == 8'd0) begin
            r = big;
        end else if (sum == 28'd0 || e == 10'd0 || e[9]) begin
            r = 32'h0000_0000;
        end else if (e >= 10'd255) begin
            r = {big[31], 8'hFF, 23'd0};
        end else begin
            r = {big[31], e[7:0], nrm[25:3]} + {31'd0, nrm[2] & (|nrm[1:0] | nrm[3])};
        end
        return r;
    endfunction

    logic [31:0] res_d;
    logic [31:0] pipe_q [LAT];

    // Opcode decode for the combinational stage.
    always_comb begin
        case (opcode)
            OP_MUL:  res_d = fp_mul(a, b);
            OP_ADD:  res_d = fp_add(a, b);
            default: res_d = 32'h0000_0000;
        endcase
    end

    // LAT-deep output pipeline; the sequencer only reads it after LAT edges of stable operands.
    always_ff @(posedge clk) begin
        pipe_q[0] <= res_d;
        for (int i = 1; i < LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign out = pipe_q[LAT-1];
endmodule

// File: tb/tb_taylor_trig_engine.sv
// Self-checking bench for taylor_trig_engine: directed vectors plus randomized requests
// compared against a direct Taylor-sum reference and the expected done latency.

module tb_taylor_trig_engine;
    localparam int  MAXT = 6;
    localparam int  AL   = 1;
    localparam real TOL  = 1.0e-5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [3:0]  n_terms = 4'd0;
    logic [31:0] x = 32'h0000_0000;
    logic        busy, done;
    logic [31:0] result;
    int          checks = 0;
    int          failures = 0;

    taylor_trig_engine #(.MAX_TERMS(MAXT), .ALU_LAT(AL)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .n_terms (n_terms),
        .x       (x),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    function automatic real fp2r(input logic [31:0] b);
        real m;
        if (b[30:23] == 8'd0) return 0.0;
        m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (real'(int'(b[30:23])) - 127.0));
        return b[31] ? -m : m;
    endfunction

    function automatic int clamp_n(input int n);
        return (n == 0) ? 1 : ((n > MAXT) ? MAXT : n);
    endfunction

    // Sum_{k<N} (-1)^k x^(2k+mode)/(2k+mode)!
    function automatic real model(input logic md, input int n, input real xv);
        real s, t;
        int  p;
        s = 0.0;
        for (int k = 0; k < clamp_n(n); k++) begin
            p = 2 * k + int'(md);
            t = 1.0;
            for (int j = 1; j <= p; j++) t = t * xv / real'(j);
            s = s + ((k % 2 == 1) ? -t : t);
        end
        return s;
    endfunction

    function automatic int exp_lat(input logic md, input int n);
        return (1 + 2 * (clamp_n(n) - 1) + int'(md)) * (AL + 1) + 1;
    endfunction

    function automatic logic [31:0] rand_x();
        logic [31:0] b;
        b[31]    = 1'($urandom);
        b[30:23] = 8'($urandom_range(126, 112));
        b[22:0]  = 23'($urandom);
        return b;
    endfunction

    function automatic real absr(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    // Issue one request; optionally keep pulsing start (random x) while it is in flight.
    task automatic run_req(input logic md, input logic [3:0] n, input logic [31:0] xb, input bit spam,
                           output logic [31:0] res, output int lat, output int busy_low);
        start = 1'b1; mode = md; n_terms = n; x = xb;
        @(posedge clk); #1;
        start = 1'b0; mode = 1'($urandom); n_terms = 4'($urandom); x = $urandom;
        lat = -1; res = 32'hFFFF_FFFF; busy_low = 0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (spam) begin start = 1'b1; x = $urandom; mode = 1'($urandom); end
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = cyc; res = result;
                break;
            end
            if (busy !== 1'b1) busy_low++;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected 00000000", result); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_spec_vectors();
        logic [31:0] r; int lat, bl;
        run_req(1'b0, 4'd6, 32'h3EE8_5696, 1'b0, r, lat, bl);
        checks++; if (!(absr(fp2r(r) - 0.898797) < TOL)) begin failures++; $display("FAIL cos_vec: got %h (%f) expected 0.898797", r, fp2r(r)); end
        checks++; if (lat !== 11 * (AL + 1) + 1) begin failures++; $display("FAIL cos_vec_lat: got %0d expected %0d", lat, 11 * (AL + 1) + 1); end
        checks++; if (bl !== 0) begin failures++; $display("FAIL cos_vec_busy: got %0d busy-low cycles expected 0", bl); end
        run_req(1'b1, 4'd4, 32'h3EE8_5696, 1'b0, r, lat, bl);
        checks++; if (!(absr(fp2r(r) - 0.438366) < TOL)) begin failures++; $display("FAIL sin_vec: got %h (%f) expected 0.438366", r, fp2r(r)); end
        checks++; if (lat !== 8 * (AL + 1) + 1) begin failures++; $display("FAIL sin_vec_lat: got %0d expected %0d", lat, 8 * (AL + 1) + 1); end
    endtask

    task automatic test_clamp();
        logic [31:0] r, xb; int lat, bl; real m;
        run_req(1'b0, 4'd0, rand_x(), 1'b0, r, lat, bl);
        checks++; if (r !== 32'h3F80_0000) begin failures++; $display("FAIL clamp0_val: got %h expected 3f800000", r); end
        checks++; if (lat !== 1 * (AL + 1) + 1) begin failures++; $display("FAIL clamp0_lat: got %0d expected %0d", lat, 1 * (AL + 1) + 1); end
        xb = rand_x();
        m  = model(1'b1, 6, fp2r(xb));
        run_req(1'b1, 4'd15, xb, 1'b0, r, lat, bl);
        checks++; if (!(absr(fp2r(r) - m) < TOL)) begin failures++; $display("FAIL clamp15_val: got %f expected %f", fp2r(r), m); end
        checks++; if (lat !== 12 * (AL + 1) + 1) begin failures++; $display("FAIL clamp15_lat: got %0d expected %0d", lat, 12 * (AL + 1) + 1); end
    endtask

    task automatic test_zero();
        logic [31:0] r; int lat, bl;
        run_req(1'b0, 4'd1, 32'h0000_0000, 1'b0, r, lat, bl);
        checks++; if (r !== 32'h3F80_0000) begin failures++; $display("FAIL zero_cos: got %h expected 3f800000", r); end
        checks++; if (lat !== 1 * (AL + 1) + 1) begin failures++; $display("FAIL zero_cos_lat: got %0d expected %0d", lat, 1 * (AL + 1) + 1); end
        run_req(1'b1, 4'd1, 32'h0000_0000, 1'b0, r, lat, bl);
        checks++; if (r !== 32'h0000_0000) begin failures++; $display("FAIL zero_sin: got %h expected 00000000", r); end
        checks++; if (lat !== 2 * (AL + 1) + 1) begin failures++; $display("FAIL zero_sin_lat: got %0d expected %0d", lat, 2 * (AL + 1) + 1); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, xb; int lat, bl, extra; real m;
        xb = rand_x();
        m  = model(1'b0, 5, fp2r(xb));
        run_req(1'b0, 4'd5, xb, 1'b1, r, lat, bl);
        checks++; if (!(absr(fp2r(r) - m) < TOL)) begin failures++; $display("FAIL b2b_val: got %f expected %f", fp2r(r), m); end
        checks++; if (lat !== exp_lat(1'b0, 5)) begin failures++; $display("FAIL b2b_lat: got %0d expected %0d", lat, exp_lat(1'b0, 5)); end
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            if (busy !== 1'b0 || done !== 1'b0) extra++;
            @(posedge clk); #1;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL b2b_quiet: got %0d active cycles after done expected 0", extra); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r, xb; int lat, bl, act; real m;
        run_req(1'b0, 4'd1, rand_x(), 1'b0, r, lat, bl);
        start = 1'b1; mode = 1'b0; n_terms = 4'd6; x = rand_x();
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1; reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b expected 0", done); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL midrst_result: got %h expected 00000000", result); end
        act = 0;
        repeat (3) begin @(posedge clk); #1; if (done !== 1'b0 || busy !== 1'b0) act++; end
        reset = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (done !== 1'b0 || busy !== 1'b0) act++; end
        checks++; if (act !== 0) begin failures++; $display("FAIL midrst_abort: got %0d active cycles expected 0", act); end
        xb = rand_x();
        m  = model(1'b0, 6, fp2r(xb));
        run_req(1'b0, 4'd6, xb, 1'b0, r, lat, bl);
        checks++; if (!(absr(fp2r(r) - m) < TOL)) begin failures++; $display("FAIL midrst_next: got %f expected %f", fp2r(r), m); end
        checks++; if (lat !== exp_lat(1'b0, 6)) begin failures++; $display("FAIL midrst_lat: got %0d expected %0d", lat, exp_lat(1'b0, 6)); end
    endtask

    task automatic test_random();
        logic [31:0] r, xb; int lat, bl, n; logic md; real m;
        for (int it = 0; it < 24; it++) begin
            md = 1'($urandom);
            n  = $urandom_range(0, 15);
            xb = ($urandom_range(0, 7) == 0) ? 32'h0000_0000 : rand_x();
            m  = model(md, n, fp2r(xb));
            run_req(md, 4'(n), xb, 1'b0, r, lat, bl);
            checks++; if (!(absr(fp2r(r) - m) < TOL)) begin failures++; $display("FAIL rand_val[%0d]: mode=%0d n=%0d x=%h got %f expected %f", it, md, n, xb, fp2r(r), m); end
            checks++; if (lat !== exp_lat(md, n)) begin failures++; $display("FAIL rand_lat[%0d]: got %0d expected %0d", it, lat, exp_lat(md, n)); end
            checks++; if (bl !== 0 || done !== 1'b0) begin failures++; $display("FAIL rand_handshake[%0d]: busy-low %0d done-after %b expected 0/0", it, bl, done); end
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_clamp();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
